alu_adder_arbiter: RTL

Shares one `adder_32bit_with_carry` instance among `NREQ` requesters. Arbitration is round-robin with a per-requester valid/ready request handshake and a one-cycle response strobe. A carry-chain lock lets one requester issue back-to-back words of a multi-precision add, with the adder's `carry_out` fed into the next word's carry-in. The block sits between the ALU front-end ports and the shared adder datapath.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/adder_32bit_with_carry.sv | 21 ++
 rtl/rr_picker.sv | 45 ++++
 rtl/alu_adder_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU adder arbiter.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot vector with bit idx set; all-zero when idx is outside 0..n-1.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_REQ) begin
      v = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/adder_32bit_with_carry.sv
// Registered 32-bit adder with carry-in and carry-out; active-high async reset.
module adder_32bit_with_carry (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  // Register A + B + carry_in every cycle; the caller holds operands stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {carry_out, sum} <= '0;
    end else begin
      {carry_out, sum} <= {1'b0, A} + {1'b0, B} + {32'd0, carry_in};
    end
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker with a forced grant for the lock holder.
module rr_picker
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            lock_vld,
  input  logic [PW-1:0]   lock_id,
  output logic [NREQ-1:0] grant
);

  // Pick the requester closest to ptr going upward with wrap, unless locked.
  always_comb begin
    int best;
    int best_d;
    int d;
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    grant  = '0;
    best   = 0;
    best_d = NREQ;
    d      = 0;
    if (lock_vld) begin
      if (req[lock_id]) begin
        grant = NREQ'(onehot(int'(lock_id), NREQ));
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          d = (i + NREQ - int'(ptr)) % NREQ;
          if (d < best_d) begin
            best_d = d;
            best   = i;
          end
        end
      end
      if (best_d < NREQ) begin
        grant = NREQ'(onehot(best, NREQ));
      end
    end
  end

endmodule

// File: rtl/alu_adder_arbiter.sv
// Shares one registered 32-bit adder among NREQ requesters with round-robin
// arbitration and a carry-chain lock for multi-precision adds.
module alu_adder_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = ALU_W,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_chain,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic            lock_vld;
  logic [PW-1:0]   lock_id;
  logic            cin_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            cin_sel_q;
  logic [PW-1:0]   id_q;
  logic            chain_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   nxt_ptr;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_cin;
  logic            sel_chain;
  logic [NREQ-1:0] id_oh;
  logic [W-1:0]    adder_sum;
  logic            adder_cout;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .lock_vld (lock_vld),
    .lock_id  (lock_id),
    .grant    (grant)
  );

  // Accept only in IDLE; held at zero while reset is asserted.
  assign req_ready = (state == IDLE && rst) ? grant : '0;

  // Steer the winner's operands and derive its index and the next pointer.
  always_comb begin
    gnt_idx   = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_cin   = 1'b0;
    sel_chain = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx   = PW'(i);
        sel_a     = req_a[i*W +: W];
        sel_b     = req_b[i*W +: W];
        sel_cin   = req_cin[i];
        sel_chain = req_chain[i];
      end
    end
    nxt_ptr = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
    id_oh   = NREQ'(onehot(int'(id_q), NREQ));
  end

  // Main FSM: accept in IDLE, let the adder sample in ADD, respond in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: operand registers are reset too so the adder never sees X after an aborted operation.
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      cin_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cin_sel_q <= 1'b0;
      id_q      <= '0;
      chain_q   <= 1'b0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      case (state)
        IDLE: begin
          if (|grant) begin
            a_q       <= sel_a;
            b_q       <= sel_b;
            cin_sel_q <= lock_vld ? cin_q : sel_cin;
            id_q      <= gnt_idx;
            chain_q   <= sel_chain;
            if (sel_chain) begin
              lock_vld <= 1'b1;
              lock_id  <= gnt_idx;
            end else begin
              rr_ptr <= nxt_ptr;
            end
            state <= ADD;
            busy  <= 1'b1;
          end
        end
        ADD: begin
          state     <= DONE;
          rsp_valid <= id_oh;
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= '0;
          cin_q     <= adder_cout;
          if (!chain_q) begin
            lock_vld <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= '0;
        end
      endcase
    end
  end

  adder_32bit_with_carry u_adder (
    .clk       (clk),
    .rst       (~rst),
    .A         (a_q),
    .B         (b_q),
    .carry_in  (cin_sel_q),
    .sum       (adder_sum),
    .carry_out (adder_cout)
  );

  assign rsp_sum  = adder_sum;
  assign rsp_cout = adder_cout;

endmodule
